mmio_slot_master: RTL and testbench
===================================

MMIO_SLOT_MASTER -- requirements
Module: mmio_slot_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  upstream request valid.
REQ-005 SHALL have port req_ready  output  1  request FIFO can accept.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  5  slot register address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response valid.
REQ-010 SHALL have port rsp_ready  input  1  response accepted.
REQ-011 SHALL have port rsp_rdata  output  32  read data; 0 for write responses.
REQ-012 SHALL have port cs  output  1  slot chip select.
REQ-013 SHALL have port read  output  1  slot read strobe.
REQ-014 SHALL have port write  output  1  slot write strobe.
REQ-015 SHALL have port addr  output  5  slot address.
REQ-016 SHALL have port wr_data  output  32  slot write data.
REQ-017 SHALL have port rd_data  input  32  slot read data, combinational from slot addr.
REQ-018 SHALL have port idle  output  1  FIFO empty and FSM in IDLE.

Function
REQ-019 SHALL push {write, addr, wdata} into the FIFO on a clock edge where req_valid && req_ready.
REQ-020 SHALL drive req_ready = !full; a pop in the same cycle SHALL NOT allow a push when full.
REQ-021 SHALL use FSM states IDLE, ACCESS, RESP.
REQ-022 IDLE with FIFO non-empty SHALL pop the head into registered addr/wr_data/op and go to ACCESS next cycle.
REQ-023 ACCESS SHALL last exactly one cycle with cs=1 and exactly one of read/write=1 per the op.
REQ-024 In ACCESS, a read SHALL capture rd_data into rsp_rdata; a write SHALL load rsp_rdata with 0.
REQ-025 ACCESS SHALL go to RESP; RESP SHALL hold rsp_valid=1 and stable rsp_rdata until rsp_ready=1, then go to IDLE.
REQ-026 cs, read and write SHALL be 0 in IDLE and RESP; addr and wr_data SHALL hold their last value.
REQ-027 Minimum latency SHALL be: push at edge N, ACCESS in cycle N+2, rsp_valid in cycle N+3.
REQ-028 Transactions SHALL reach the slot in acceptance order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 Push and pop in the same cycle with FIFO neither empty nor full SHALL leave the occupancy unchanged.
REQ-030 idle SHALL be 1 only when the FIFO is empty and the state is IDLE.

Reset
REQ-031 On a clk edge with reset_n=0, SHALL set state=IDLE, FIFO empty, rsp_valid=0, rsp_rdata=0, cs=read=write=0, addr=0, wr_data=0, req_ready=1.
REQ-032 Reset in ACCESS or RESP SHALL discard the in-flight transaction and all queued entries, with no response.

Configuration
REQ-033 With macro MMIO_SLOT_MASTER_POSTED_WRITE_EN defined, a write SHALL go from ACCESS to IDLE with no response; only reads produce rsp_valid.
REQ-034 Without MMIO_SLOT_MASTER_POSTED_WRITE_EN, every write SHALL produce one response with rsp_rdata=0, per REQ-025.

Verification
REQ-035 Read addr=5'h01, slot rd_data=32'h0000_1234 during ACCESS -> one-cycle cs=1, read=1, addr=1; then rsp_valid with rsp_rdata=32'h0000_1234.
REQ-036 Write addr=5'h02, wdata=32'h3 -> one-cycle cs=1, write=1, wr_data=3; response with rdata=0, or none if posted.
REQ-037 Push 4 requests with rsp_ready=0 and FIFO_DEPTH=4 -> req_ready=0 after the 4th push and a 5th request is held; slot accesses follow push order once rsp_ready=1.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and no new cs pulse occurs.
REQ-039 Assert reset_n=0 for 1 cycle during RESP with 2 entries queued -> idle=1, rsp_valid=0, and no further cs pulses.
REQ-040 Back-to-back reads with rsp_ready=1 -> exactly one cs pulse per transaction, at most one transaction every 3 cycles.

Source files
------------

// File: rtl/mmio_slot_master.sv
// Queued MMIO master: buffers upstream requests in a FIFO and replays them one at a time onto a slot register bus.
// Optional MMIO_SLOT_MASTER_POSTED_WRITE_EN: writes complete without producing a response.
module mmio_slot_master #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        cs,
   output logic        read,
   output logic        write,
   output logic [4:0]  addr,
   output logic [31:0] wr_data,
   input  logic [31:0] rd_data,
   output logic        idle
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t         state;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           op_write;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;

   logic           fifo_write [FIFO_DEPTH];
   logic [4:0]     fifo_addr  [FIFO_DEPTH];
   logic [31:0]    fifo_wdata [FIFO_DEPTH];

   // Push is gated on !full alone, so a same-cycle pop never frees room for a push.
   assign full      = (count == CNT_FULL);
   assign empty     = (count == '0);
   assign push      = req_valid && !full;
   assign pop       = (state == IDLE) && !empty;
   assign req_ready = !full;
   assign idle      = empty && (state == IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_write[wr_ptr] <= req_write;
         fifo_addr[wr_ptr]  <= req_addr;
         fifo_wdata[wr_ptr] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Slot strobes are raised on entry to ACCESS so they are high for exactly that cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         op_write  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         cs        <= 1'b0;
         read      <= 1'b0;
         write     <= 1'b0;
         addr      <= '0;
         wr_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  op_write <= fifo_write[rd_ptr];
                  addr     <= fifo_addr[rd_ptr];
                  wr_data  <= fifo_wdata[rd_ptr];
                  cs       <= 1'b1;
                  read     <= !fifo_write[rd_ptr];
                  write    <= fifo_write[rd_ptr];
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               cs    <= 1'b0;
               read  <= 1'b0;
               write <= 1'b0;
               rsp_rdata <= op_write ? 32'd0 : rd_data;
`ifdef MMIO_SLOT_MASTER_POSTED_WRITE_EN
               if (op_write) begin
                  state <= IDLE;
               end else begin
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
`else
               rsp_valid <= 1'b1;
               state     <= RESP;
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_slot_master.sv
// Randomized self-checking bench for mmio_slot_master; a queue-based model predicts slot accesses and responses.
module tb_mmio_slot_master;

   localparam int DEPTH = 4;
`ifdef MMIO_SLOT_MASTER_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   typedef struct packed {
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
   } txn_t;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        idle;

   logic [31:0] slot_tbl [32];
   txn_t        acc_q [$];
   logic [31:0] rsp_q [$];

   int total;
   int bad;
   int cycle;
   int last_cs_cycle;
   bit cs_seen_valid;
   int cs_count;
   int rsp_seen;
   int rsp_exp;

   mmio_slot_master #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .cs        (cs),
      .read      (read),
      .write     (write),
      .addr      (addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data),
      .idle      (idle)
   );

   // The slot is a fixed lookup table read combinationally from the slot address.
   assign rd_data = slot_tbl[addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Accepted requests must reach the slot in order; each access defines the next expected response.
   initial begin
      txn_t e;
      forever begin
         @(negedge clk);
         cycle++;
         if (!reset_n) begin
            acc_q.delete();
            rsp_q.delete();
            cs_seen_valid = 1'b0;
         end else begin
            if (cs) begin
               cs_count++;
               if (cs_seen_valid)
                  checkOutput("cs_spacing", 32'((cycle - last_cs_cycle) >= 3), 32'd1);
               last_cs_cycle = cycle;
               cs_seen_valid = 1'b1;
               if (acc_q.size() == 0) begin
                  checkOutput("cs_unexpected", 32'd1, 32'd0);
               end else begin
                  e = acc_q.pop_front();
                  checkOutput("acc_addr", 32'(addr), 32'(e.a));
                  checkOutput("acc_strobe", 32'({write, read}), e.w ? 32'd2 : 32'd1);
                  if (e.w) begin
                     checkOutput("acc_wdata", wr_data, e.d);
                     if (!POSTED) rsp_q.push_back(32'd0);
                  end else begin
                     rsp_q.push_back(slot_tbl[e.a]);
                  end
               end
            end else begin
               checkOutput("strobe_idle", 32'({write, read}), 32'd0);
            end
            if (rsp_valid && rsp_ready) begin
               rsp_seen++;
               if (rsp_q.size() == 0) checkOutput("rsp_unexpected", 32'd1, 32'd0);
               else                   checkOutput("rsp_rdata", rsp_rdata, rsp_q.pop_front());
            end
            if (req_valid && req_ready) begin
               acc_q.push_back({req_write, req_addr, req_wdata});
               if (!req_write || !POSTED) rsp_exp++;
            end
         end
      end
   end

   task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            return;
         end
      end
      checkOutput("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic waitRsp();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rsp_valid) return;
      end
      checkOutput("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (idle && !rsp_valid) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      checkOutput("idle_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c0;
      int rs0;
      int re0;
      int sent;
      bit acc;
      logic [31:0] hold;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 32; i++) slot_tbl[i] = $urandom;
      slot_tbl[1] = 32'h0000_1234;

      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_idle", 32'(idle), 32'd1);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_strobes", 32'({cs, read, write}), 32'd0);
      checkOutput("rst_addr", 32'(addr), 32'd0);
      checkOutput("rst_wr_data", wr_data, 32'd0);
      @(posedge clk);
      #1;

      // Single read: minimum latency and captured slot data.
      applyStimulus(1'b0, 5'h01, 32'd0);
      @(negedge clk);
      checkOutput("lat_cs_early", 32'(cs), 32'd0);
      @(negedge clk);
      checkOutput("rd_cs", 32'(cs), 32'd1);
      checkOutput("rd_read", 32'(read), 32'd1);
      checkOutput("rd_addr", 32'(addr), 32'd1);
      @(negedge clk);
      checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
      checkOutput("rd_cs_after", 32'(cs), 32'd0);
      @(posedge clk);
      #1;
      waitIdle();

      // Single write.
      applyStimulus(1'b1, 5'h02, 32'h3);
      @(negedge clk);
      @(negedge clk);
      checkOutput("wr_cs", 32'(cs), 32'd1);
      checkOutput("wr_strobes", 32'({read, write}), 32'd1);
      checkOutput("wr_data", wr_data, 32'h3);
      checkOutput("wr_addr", 32'(addr), 32'd2);
      @(negedge clk);
      checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'(!POSTED));
      checkOutput("wr_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk);
      #1;
      waitIdle();

      // Stalled response stays stable, then the FIFO fills behind it.
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 5'h07, 32'd0);
      hold = slot_tbl[7];
      waitRsp();
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
         checkOutput("hold_rdata", rsp_rdata, hold);
         checkOutput("hold_cs", 32'(cs), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      @(negedge clk);
      checkOutput("full_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      req_write = 1'b0;
      req_addr  = 5'h1f;
      req_wdata = '0;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("held_ready", 32'(req_ready), 32'd0);
         checkOutput("held_cs", 32'(cs), 32'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      applyStimulus(1'b0, 5'h1f, 32'd0);
      waitIdle();

      // Reset while a response is pending and two entries are queued.
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 5'h03, 32'd0);
      waitRsp();
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 5'h04, 32'd0);
      applyStimulus(1'b0, 5'h05, 32'd0);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("rst2_idle", 32'(idle), 32'd1);
      checkOutput("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst2_req_ready", 32'(req_ready), 32'd1);
      c0 = cs_count;
      repeat (10) @(negedge clk);
      checkOutput("rst2_no_cs", 32'(cs_count - c0), 32'd0);
      @(posedge clk);
      #1;

      // Back-to-back reads: one slot access per transaction.
      c0 = cs_count;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'(i + 8), 32'd0);
      waitIdle();
      checkOutput("b2b_cs_count", 32'(cs_count - c0), 32'd4);

      // Randomized traffic with random response back-pressure.
      rs0  = rsp_seen;
      re0  = rsp_exp;
      sent = 0;
      for (int cyc = 0; cyc < 6000 && sent < 150; cyc++) begin
         if (!req_valid && $urandom_range(0, 2) != 0) begin
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 5'($urandom);
            req_wdata = $urandom;
            req_valid = 1'b1;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      checkOutput("rand_sent", 32'(sent), 32'd150);
      waitIdle();
      checkOutput("rand_rsp_count", 32'(rsp_seen - rs0), 32'(rsp_exp - re0));
      checkOutput("rand_acc_left", 32'(acc_q.size()), 32'd0);
      checkOutput("rand_rsp_left", 32'(rsp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
